// File: rtl/fft_pair_buffer_pkg.sv
// Shared FFT sample and bus types.
// Used by the pairing buffer and the butterfly.
package fft_pair_buffer_pkg;

  localparam int FFT_W = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } FFT_DATA_SAMPLE;

  typedef struct packed {
    logic           valid;
    FFT_DATA_SAMPLE data;
  } FFT_DATA_BUS;

endpackage

// File: rtl/fft_pair_buffer_if.sv
// Bundle for the pairing buffer: in/flush toward the DUT,
// up/down/phase/frame_done back from it.
interface fft_pair_buffer_if;
  import fft_pair_buffer_pkg::*;

  FFT_DATA_BUS in;
  logic        flush;
  FFT_DATA_BUS up;
  FFT_DATA_BUS down;
  logic        phase;
  logic        frame_done;

  modport master (
    output in,
    output flush,
    input  up,
    input  down,
    input  phase,
    input  frame_done
  );

  modport slave (
    input  in,
    input  flush,
    output up,
    output down,
    output phase,
    output frame_done
  );

endinterface

// File: rtl/fft_pair_buffer_pair_store.sv
// Half-frame sample store: one write port, one
// registered read port (rdata valid the cycle after re).
module pair_store
  import fft_pair_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  FFT_DATA_SAMPLE wdata,
  input  logic           re,
  input  logic [AW-1:0]  raddr,
  output FFT_DATA_SAMPLE rdata
);

  FFT_DATA_SAMPLE mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_pair_buffer.sv
// Pairs x[k] with x[k+POINT/2] for the butterfly.
// Ports: clk, rst (sync, high), bus (slave side).
module fft_pair_buffer
  import fft_pair_buffer_pkg::*;
#(
  parameter int POINT = 8,
  parameter int SET   = $clog2(POINT)
) (
  input  logic               clk,
  input  logic               rst,
  fft_pair_buffer_if.slave   bus
);

  localparam int HALF = POINT / 2;
  localparam int AW   = SET - 1;
  localparam logic [SET-1:0] LAST = SET'(POINT - 1);

  logic [SET-1:0] cnt;
  logic           pair_v;
  logic           fd_q;
  FFT_DATA_SAMPLE down_q;
  FFT_DATA_SAMPLE rd;

  logic acc;
  logic in_pair;
  logic we;
  logic re;

  assign acc     = bus.in.valid & ~bus.flush;
  assign in_pair = cnt[SET-1];
  assign we      = acc & ~in_pair;
  assign re      = acc & in_pair;

  pair_store #(
    .DEPTH (HALF),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (cnt[AW-1:0]),
    .wdata (bus.in.data),
    .re    (re),
    .raddr (cnt[AW-1:0]),
    .rdata (rd)
  );

  logic [SET-1:0] cnt_n;
  logic           pair_v_n;
  logic           fd_n;

  always_comb begin
    cnt_n    = cnt;
    pair_v_n = 1'b0;
    fd_n     = 1'b0;
    unique case (1'b1)
      bus.flush: begin
        cnt_n = '0;
      end
      we: begin
        cnt_n = cnt + 1'b1;
      end
      re: begin
        cnt_n    = cnt + 1'b1;
        pair_v_n = 1'b1;
        fd_n     = (cnt == LAST);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      pair_v <= 1'b0;
      fd_q   <= 1'b0;
      down_q <= '0;
    end else begin
      cnt    <= cnt_n;
      pair_v <= pair_v_n;
      fd_q   <= fd_n;
      if (re) begin
        down_q <= bus.in.data;
      end
    end
  end

  assign bus.up         = '{valid: pair_v, data: rd};
  assign bus.down       = '{valid: pair_v, data: down_q};
  assign bus.phase      = cnt[SET-1];
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_fft_pair_buffer.sv
// Scoreboard bench for fft_pair_buffer (POINT=8).
// Expected pairs are queued by stimulus, popped by the monitor.
module tb_fft_pair_buffer;
  import fft_pair_buffer_pkg::*;

  typedef struct {
    int u;
    int d;
    bit fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t q [$];

  fft_pair_buffer_if bus ();

  fft_pair_buffer #(.POINT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.up.valid || bus.down.valid || bus.frame_done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out up=%0d/%0d down=%0d/%0d fd=%0d required none",
                   bus.up.valid, bus.up.data.re, bus.down.valid,
                   bus.down.data.re, bus.frame_done);
        end else begin
          e = q.pop_front();
          if (bus.up.valid !== 1'b1 || bus.down.valid !== 1'b1 ||
              int'(bus.up.data.re) != e.u ||
              int'(bus.down.data.re) != e.d ||
              bus.up.data.im !== '0 || bus.down.data.im !== '0 ||
              bus.frame_done !== e.fd) begin
            errors++;
            $display("FAIL pair v=%0d%0d up=%0d down=%0d fd=%0d required up=%0d down=%0d fd=%0d",
                     bus.up.valid, bus.down.valid, bus.up.data.re,
                     bus.down.data.re, bus.frame_done, e.u, e.d, e.fd);
          end
        end
      end
    end
  end

  task automatic drive(input int v_re, input bit v, input bit fl);
    bus.in.valid   = v;
    bus.in.data.re = 16'(v_re);
    bus.in.data.im = '0;
    bus.flush      = fl;
    @(posedge clk);
    #1;
    bus.in.valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic chk_phase(input string nm, input bit p);
    checks++;
    if (bus.phase !== p) begin
      errors++;
      $display("FAIL %s phase=%0d required %0d", nm, bus.phase, p);
    end
  endtask

  task automatic frame(input int base, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) q.push_back('{base + i - 4, base + i, i == 7});
      drive(base + i, 1'b1, 1'b0);
      chk_phase("frame_phase", ((i + 1) % 8) >= 4);
      if (gaps) drive(0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (bus.up !== '0 || bus.down !== '0 ||
        bus.frame_done !== 1'b0 || bus.phase !== 1'b0) begin
      errors++;
      $display("FAIL %s up=%h down=%h fd=%0d phase=%0d required all 0",
               nm, bus.up, bus.down, bus.frame_done, bus.phase);
    end
  endtask

  initial begin
    bus.in    = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 1'b0;

    frame(1, 1'b0);
    drive(0, 1'b0, 1'b0);

    frame(1, 1'b1);

    frame(1, 1'b0);
    frame(9, 1'b0);
    drive(0, 1'b0, 1'b0);

    for (int i = 1; i <= 5; i++) begin
      if (i == 5) q.push_back('{1, 5, 1'b0});
      drive(i, 1'b1, 1'b0);
    end
    drive(6, 1'b1, 1'b1);
    chk_phase("flush_phase", 1'b0);
    drive(7, 1'b0, 1'b0);
    frame(21, 1'b0);

    for (int i = 1; i <= 3; i++) drive(i, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("mid_reset");
    rst = 1'b0;
    frame(1, 1'b0);

    for (int i = 1; i <= 7; i++) begin
      if (i >= 5) q.push_back('{i - 4, i, 1'b0});
      drive(i, 1'b1, 1'b0);
    end
    drive(8, 1'b1, 1'b1);
    chk_phase("flush_last_phase", 1'b0);
    frame(31, 1'b0);

    repeat (3) drive(0, 1'b0, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_pair_buffer.md
# fft_pair_buffer

Input pairing stage placed directly upstream of the `butterfly` in each radix-2 FFT stage. It accepts a serial stream of complex samples, holds the first half of each `POINT`-sample frame, and then presents sample `k` and sample `k+POINT/2` together on the butterfly's `up`/`down` buses. The output pairs are ordered k = 0 … POINT/2−1, which matches the butterfly's internal twiddle index sequence.

## Interface
**Parameters**
- `POINT`, default 8: frame length. Must be a power of two and at least 4.
- `SET`, default `$clog2(POINT)`: width of the sample counter.

**Ports** (`FFT_DATA_BUS` = {`valid`, `data`: `FFT_DATA_SAMPLE`})
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `in`, input, `FFT_DATA_BUS`: serial input sample stream. There is no backpressure.
- `flush`, input, 1: synchronous abort of the current frame.
- `up`, output, `FFT_DATA_BUS`: buffered first-half sample `x[k]`.
- `down`, output, `FFT_DATA_BUS`: live second-half sample `x[k+POINT/2]`.
- `phase`, output, 1: 0 = FILL, 1 = PAIR. Decoded from the counter MSB.
- `frame_done`, output, 1: one-cycle pulse, aligned with the last pair of a frame.

## Operation
- `cnt[SET-1:0]` counts accepted samples. An accepted sample is `in.valid`=1 with `flush`=0.
- `cnt` increments only on accepted samples. It wraps from POINT−1 to 0, so back-to-back frames need no idle cycle.
- State is decoded from the counter MSB:
  - FILL when `cnt[SET-1]`=0.
  - PAIR when `cnt[SET-1]`=1.
  - There is no separate FSM register.
- FILL, on an accepted sample:
  - Write `in.data` to `buf[cnt[SET-2:0]]`.
  - `up.valid` and `down.valid` are 0 on the next cycle.
- PAIR, on an accepted sample:
  - Next cycle: `up.data` = `buf[cnt[SET-2:0]]`, `down.data` = `in.data`, and `up.valid` = `down.valid` = 1.
  - If `cnt` = POINT−1, also pulse `frame_done` on that same output cycle.
- `in.valid`=0:
  - Counter and buffer are held.
  - Next-cycle output valids and `frame_done` are 0.
  - Data outputs hold their last values.
- The buffer holds POINT/2 entries of `FFT_DATA_SAMPLE`.
  - It is written only in FILL and read only in PAIR, so there is no read/write collision.
  - Contents are not cleared by reset or flush. They are overwritten by the next FILL.
- `flush`=1:
  - Next cycle: `cnt`=0, valids 0, `frame_done` 0.
  - The input sample on the flush cycle is dropped; flush wins over a simultaneous `in.valid`.
- `up.valid` and `down.valid` are always equal. The butterfly requires both together.

## Timing
- Latency: input sample to its paired output is 1 cycle. All outputs are registered.
- Reset values:
  - `up` and `down` valids and data = 0.
  - `frame_done` = 0.
  - `phase` = 0.
  - `cnt` = 0.
- Reset asserted mid-frame:
  - The partial frame is discarded.
  - The first accepted sample after `rst` deasserts is treated as `x[0]`.
- Throughput: one sample per cycle sustained. Output pairs are emitted at the input rate during PAIR, and there are no outputs during FILL.
- `phase` changes the cycle after the accepted sample that moves `cnt` across POINT/2 or wraps it to 0.

## Structure
- In the shared FFT package: `FFT_DATA_SAMPLE`, `FFT_DATA_BUS`, and the sample width constant, shared with `butterfly`.
- Sub-module `pair_store`:
  - POINT/2 × `FFT_DATA_SAMPLE` array.
  - One write port (`we`, `waddr`, `wdata`) and one registered read port (`re`, `raddr`, `rdata`).
  - The top level contains only the counter, gating, and output registers.

## Test plan
- POINT=8, inputs 1…8 (real part, imag 0), valid every cycle:
  - Pairs (1,5), (2,6), (3,7), (4,8) on 4 consecutive cycles, starting 1 cycle after sample 5.
  - `frame_done` with the (4,8) pair.
- Same frame with `in.valid` low on every other cycle:
  - Identical pairs, each 1 cycle after its second-half sample.
  - No output valids in between.
- Two back-to-back frames, 1…8 then 9…16, with no gap:
  - Second frame pairs are (9,13) … (12,16).
  - `frame_done` pulses twice.
  - `phase` toggles every 4 samples.
- `flush` asserted with sample 6 of 1…8, then frame 21…28:
  - Sample 6 is dropped and no further pairs come from the first frame.
  - Output pairs are (21,25) … (24,28).
- `rst` asserted after sample 3, then frame 1…8:
  - The cycle after `rst`, all outputs are 0.
  - Output pairs are (1,5) … (4,8).
- Simultaneous `flush` and `in.valid` on the last sample of a frame:
  - No output pair for that sample.
  - No `frame_done` pulse.
  - `cnt` returns to 0.
